pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the single-bit full adder.
- Computes WIDTH-bit add or subtract, with carry/borrow in, as a ripple of SEG-bit segments.
- One pipeline register stage per segment, so the critical path is one segment, not the full word.
- Sits between the register file read ports and the ALU result mux; valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; 1 <= SEG <= WIDTH.
- STAGES, WIDTH/SEG, derived (localparam), pipeline depth = latency in cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- op  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out (add); NOT-borrow (sub).
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset is asynchronous and active-low (rst_n). While low:
  - all stage valid bits, out_valid, sum, cout, ovf = 0;
  - zero = 1, since it is derived from sum.
  - Asserting rst_n mid-operation discards all in-flight beats; no partial result ever appears.
- Arithmetic:
  - op=0: {cout,sum} = A + B + cin.
  - op=1: {cout,sum} = A + ~B + ~cin, i.e. A - B - cin; cout=1 means no borrow.
  - ovf = carry into MSB XOR carry out of MSB.
  - All wrap modulo 2^WIDTH.
- Pipeline:
  - Stage k (0..STAGES-1) resolves bits [k*SEG +: SEG] from its registered segment operands and the carry registered by stage k-1.
  - Stage 0 carry-in is cin XOR op.
  - Not-yet-resolved upper operand segments travel with the beat; resolved lower sum segments are carried forward.
  - op is applied (B inversion) at stage-0 capture.
  - Final stage holds sum, cout, ovf; out_valid = final stage valid.
- Latency: exactly STAGES cycles from in_valid&&in_ready to out_valid, with no stall. Throughput is one beat per cycle.
- Handshake:
  - Transfer on valid&&ready at each side.
  - Stage k advances when its successor is empty or advancing; the final stage advances on out_ready.
  - in_ready = stage 0 can accept. It may depend combinationally on out_ready; no ready-to-valid combinational path.
  - Once out_valid is high, sum/cout/ovf/zero and out_valid are held stable until out_ready.
  - in_valid may drop at any time with no effect on in-flight beats.
- Boundaries:
  - Full pipeline with out_ready=0: in_ready=0, no beat lost or duplicated.
  - Full pipeline with out_ready=1 and in_valid=1: simultaneous accept and emit, occupancy constant.
  - Empty pipeline: in_ready=1 regardless of out_ready.
  - Bubbles propagate as invalid stages and compress only when the downstream stalls.
- SEG=WIDTH gives a single-stage registered adder (latency 1). SEG=1 gives a bit-serial-per-stage pipeline (latency WIDTH).

Test Plan:
- Reset mid-stream: 3 beats in flight, rst_n low 1 cycle -> out_valid=0 immediately, sum=0, zero=1; no stale beat emitted after release.
- Add, WIDTH=16, SEG=4, out_ready=1: a=16'hFFFF, b=16'h0001, cin=0, op=0 -> after 4 cycles sum=16'h0000, cout=1, ovf=0, zero=1.
- Signed overflow: a=16'h7FFF, b=16'h0001, op=0 -> sum=16'h8000, ovf=1, cout=0. Then a=16'h8000, b=16'h0001, op=1, cin=0 -> sum=16'h7FFF, ovf=1, cout=1.
- Borrow: a=16'h0003, b=16'h0005, op=1, cin=1 -> sum=16'hFFFD, cout=0, ovf=0.
- Back-pressure: stream 10 random beats back-to-back, out_ready low cycles 3-8 -> in_ready deasserts after 4 accepted beats. All 10 results emitted in order, matching the reference model, with outputs stable while stalled.
- Sweep SEG in {1,4,16} with 1000 random beats and random in_valid/out_ready -> results match the A±B±cin model; latency equals STAGES whenever unstalled.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract that resolves SEG bits per stage, with
// valid/ready flow control on both the operand and the result side.
module pipelined_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned STAGES = WIDTH / SEG;
  localparam int unsigned LAST   = STAGES - 1;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] accept;
  logic [STAGES-1:0] load;
  logic              leave;

  // Ready chain from the output backwards: a stage accepts when empty or when
  // its own beat moves on; src_v[k] is the valid of whatever feeds stage k.
  always_comb begin
    valid_d = valid_q;
    accept  = '0;
    load    = '0;
    src_v   = (valid_q << 1) | STAGES'(in_valid);
    leave   = valid_q[LAST] && out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      accept[k] = !valid_q[k] || leave;
      leave     = src_v[k] && accept[k];
      load[k]   = leave;
      if (accept[k]) begin
        valid_d[k] = src_v[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * SEG;
    localparam int unsigned HI = LO + SEG;

    logic [WIDTH-LO-1:0] a_in;
    logic [WIDTH-LO-1:0] b_in;
    logic                c_in;
    logic [SEG:0]        seg_res;
    logic [HI-1:0]       s_d;
    logic [HI-1:0]       s_q;
    logic                c_q;

    // Stage 0 applies op: subtraction is A + ~B + ~cin.
    if (k == 0) begin : g_first
      assign a_in = a;
      assign b_in = b ^ {WIDTH{op}};
      assign c_in = cin ^ op;
      assign s_d  = seg_res[SEG-1:0];
    end else begin : g_next
      assign a_in = g_stage[k-1].g_mid.a_rem_q;
      assign b_in = g_stage[k-1].g_mid.b_rem_q;
      assign c_in = g_stage[k-1].c_q;
      assign s_d  = {seg_res[SEG-1:0], g_stage[k-1].s_q};
    end

    assign seg_res = (SEG+1)'(a_in[SEG-1:0]) + (SEG+1)'(b_in[SEG-1:0])
                   + (SEG+1)'(c_in);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (load[k]) begin
        s_q <= s_d;
        c_q <= seg_res[SEG];
      end
    end

    if (k < LAST) begin : g_mid
      localparam int unsigned REM = WIDTH - HI;
      logic [REM-1:0] a_rem_q;
      logic [REM-1:0] b_rem_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (load[k]) begin
          a_rem_q <= a_in[WIDTH-LO-1:SEG];
          b_rem_q <= b_in[WIDTH-LO-1:SEG];
        end
      end
    end else begin : g_last
      logic ovf_q;
      logic zero_q;

      // Carry into the MSB is a^b^s at that bit; overflow is it XOR carry-out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b1;
        end else if (load[k]) begin
          ovf_q  <= a_in[SEG-1] ^ b_in[SEG-1] ^ seg_res[SEG-1] ^ seg_res[SEG];
          zero_q <= (s_d == '0);
        end
      end
    end
  end

  assign in_ready  = accept[0];
  assign out_valid = valid_q[LAST];
  assign sum       = g_stage[LAST].s_q;
  assign cout      = g_stage[LAST].c_q;
  assign ovf       = g_stage[LAST].g_last.ovf_q;
  assign zero      = g_stage[LAST].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three instances (SEG = 1, 4, 16) checked against
// an arithmetic reference model through a result scoreboard.
module tb_pipelined_addsub;

  localparam int unsigned W  = 16;
  localparam int unsigned NI = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv    [NI];
  logic         irdy  [NI];
  logic [W-1:0] ia    [NI];
  logic [W-1:0] ib    [NI];
  logic         icin  [NI];
  logic         iop   [NI];
  logic         ovalid[NI];
  logic         ordy  [NI];
  logic [W-1:0] osum  [NI];
  logic         ocout [NI];
  logic         oovf  [NI];
  logic         ozero [NI];

  int           checks;
  int           errors;
  int           cyc;
  bit           lat_chk;
  logic [18:0]  exp_q [NI][$];
  int           acc_q [NI][$];
  int           emit_cnt [NI];
  int           acc_cnt  [NI];
  bit           stall [NI];
  logic [18:0]  held  [NI];
  logic [18:0]  mon_e;
  int           mon_t;
  logic [W-1:0] corners [4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    pipelined_addsub #(
      .WIDTH (W),
      .SEG   (gi == 0 ? 1 : (gi == 1 ? 4 : 16))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[gi]),
      .in_ready  (irdy[gi]),
      .a         (ia[gi]),
      .b         (ib[gi]),
      .cin       (icin[gi]),
      .op        (iop[gi]),
      .out_valid (ovalid[gi]),
      .out_ready (ordy[gi]),
      .sum       (osum[gi]),
      .cout      (ocout[gi]),
      .ovf       (oovf[gi]),
      .zero      (ozero[gi])
    );
  end

  function automatic int stages_of(input int i);
    return (i == 0) ? 16 : ((i == 1) ? 4 : 1);
  endfunction

  // Reference: {cout, ovf, zero, sum} from unsigned and signed integer arithmetic.
  function automatic logic [18:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c, input logic o);
    int          ux, uy, sx, sy, full, sres;
    logic        co, ov;
    logic [W-1:0] s;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!o) begin
      full = ux + uy + int'(c);
      sres = sx + sy + int'(c);
      co   = (full > 65535);
    end else begin
      full = ux - uy - int'(c);
      sres = sx - sy - int'(c);
      co   = (full >= 0);
    end
    s  = 16'(full);
    ov = (sres > 32767) || (sres < -32768);
    return {co, ov, (s == 16'h0000), s};
  endfunction

  function automatic logic [18:0] outs(input int i);
    return {ocout[i], oovf[i], ozero[i], osum[i]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: records accepted beats, retires emitted ones, and checks holds.
  always begin
    @(negedge clk);
    #2;
    cyc++;
    for (int i = 0; i < int'(NI); i++) begin
      if (!rst_n) begin
        exp_q[i].delete();
        acc_q[i].delete();
        stall[i] = 1'b0;
      end else begin
        if (stall[i]) begin
          check($sformatf("hold_valid[%0d]", i), 32'(ovalid[i]), 32'd1);
          check($sformatf("hold_data[%0d]", i), 32'(outs(i)), 32'(held[i]));
        end
        if (ovalid[i] && ordy[i]) begin
          emit_cnt[i]++;
          check($sformatf("exp_avail[%0d]", i), 32'(exp_q[i].size() > 0), 32'd1);
          if (exp_q[i].size() > 0) begin
            mon_e = exp_q[i].pop_front();
            mon_t = acc_q[i].pop_front();
            check($sformatf("result[%0d]", i), 32'(outs(i)), 32'(mon_e));
            if (lat_chk) begin
              check($sformatf("latency[%0d]", i), 32'(cyc - mon_t), 32'(stages_of(i)));
            end
          end
        end
        if (iv[i] && irdy[i]) begin
          exp_q[i].push_back(model(ia[i], ib[i], icin[i], iop[i]));
          acc_q[i].push_back(cyc);
          acc_cnt[i]++;
        end
        stall[i] = ovalid[i] && !ordy[i];
        held[i]  = outs(i);
      end
    end
  end

  task automatic idle_all();
    for (int i = 0; i < int'(NI); i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
  endtask

  task automatic send_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic o, input logic [18:0] exp);
    @(negedge clk);
    iv[1]   = 1'b1;
    ia[1]   = x;
    ib[1]   = y;
    icin[1] = c;
    iop[1]  = o;
    ordy[1] = 1'b1;
    #1 check({tag, "_accept"}, 32'(irdy[1]), 32'd1);
    @(negedge clk);
    iv[1] = 1'b0;
    repeat (stages_of(1) - 2) @(negedge clk);
    #3 check({tag, "_early"}, 32'(ovalid[1]), 32'd0);
    @(negedge clk);
    #3 check({tag, "_valid"}, 32'(ovalid[1]), 32'd1);
    check({tag, "_result"}, 32'(outs(1)), 32'(exp));
  endtask

  task automatic drive_random(input int pv, input int pr);
    @(negedge clk);
    for (int i = 0; i < int'(NI); i++) begin
      iv[i]   = int'($urandom_range(99)) < pv;
      ia[i]   = ($urandom_range(7) == 0) ? corners[$urandom_range(3)] : 16'($urandom);
      ib[i]   = ($urandom_range(7) == 0) ? corners[$urandom_range(3)] : 16'($urandom);
      icin[i] = 1'($urandom);
      iop[i]  = 1'($urandom);
      ordy[i] = int'($urandom_range(99)) < pr;
    end
  endtask

  task automatic drain(input string tag);
    bit empty;
    @(negedge clk);
    idle_all();
    empty = 1'b0;
    for (int n = 0; n < 100 && !empty; n++) begin
      @(negedge clk);
      #3;
      empty = 1'b1;
      for (int i = 0; i < int'(NI); i++) begin
        if (exp_q[i].size() != 0) empty = 1'b0;
      end
    end
    for (int i = 0; i < int'(NI); i++) begin
      check($sformatf("%s_drained[%0d]", tag, i), 32'(exp_q[i].size()), 32'd0);
    end
  endtask

  initial begin
    int  sent, first_drop, base, got;
    int  base_acc [NI];
    bit  done;

    corners = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    lat_chk = 1'b0;
    rst_n   = 1'b0;
    for (int i = 0; i < int'(NI); i++) begin
      iv[i]   = 1'b0;
      ia[i]   = '0;
      ib[i]   = '0;
      icin[i] = 1'b0;
      iop[i]  = 1'b0;
      ordy[i] = 1'b0;
    end

    // Reset state, and empty pipeline ready regardless of out_ready.
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < int'(NI); i++) begin
      check($sformatf("rst_valid[%0d]", i), 32'(ovalid[i]), 32'd0);
      check($sformatf("rst_outs[%0d]", i), 32'(outs(i)), 32'h1_0000);
      check($sformatf("rst_ready_stall[%0d]", i), 32'(irdy[i]), 32'd1);
      ordy[i] = 1'b1;
    end
    #1;
    for (int i = 0; i < int'(NI); i++) begin
      check($sformatf("rst_ready_go[%0d]", i), 32'(irdy[i]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic on the SEG=4 instance.
    send_one("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 19'h5_0000);
    send_one("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 19'h2_8000);
    send_one("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 19'h6_7FFF);
    send_one("sub_brw",  16'h0003, 16'h0005, 1'b1, 1'b1, 19'h0_FFFD);

    // Back-pressure: out_ready low during cycles 3..8 of a 10-beat burst.
    sent       = 0;
    first_drop = -1;
    base       = emit_cnt[1];
    for (int c = 0; c < 40 && sent < 10; c++) begin
      @(negedge clk);
      ordy[1] = !(c >= 3 && c <= 8);
      iv[1]   = 1'b1;
      ia[1]   = 16'($urandom);
      ib[1]   = 16'($urandom);
      icin[1] = 1'($urandom);
      iop[1]  = 1'($urandom);
      #1;
      if (irdy[1]) sent++;
      else if (first_drop < 0) first_drop = sent;
    end
    @(negedge clk);
    iv[1]   = 1'b0;
    ordy[1] = 1'b1;
    for (int n = 0; n < 40 && (emit_cnt[1] - base) < 10; n++) @(negedge clk);
    #3;
    check("bp_first_stall", 32'(first_drop), 32'd4);
    check("bp_sent", 32'(sent), 32'd10);
    check("bp_emitted", 32'(emit_cnt[1] - base), 32'd10);

    // Reset with three beats in flight and the oldest waiting at the output.
    @(negedge clk);
    ordy[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[1]   = 1'b1;
      ia[1]   = 16'($urandom);
      ib[1]   = 16'($urandom);
      icin[1] = 1'($urandom);
      iop[1]  = 1'($urandom);
      #1 check("rst_fill_ready", 32'(irdy[1]), 32'd1);
      @(negedge clk);
    end
    iv[1] = 1'b0;
    got   = 0;
    for (int n = 0; n < 10 && got == 0; n++) begin
      #2;
      if (ovalid[1]) got = 1;
      else @(negedge clk);
    end
    check("rst_mid_reached_out", 32'(got), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(ovalid[1]), 32'd0);
    check("rst_mid_outs", 32'(outs(1)), 32'h1_0000);
    @(negedge clk);
    #3 rst_n = 1'b1;
    ordy[1] = 1'b1;
    base    = emit_cnt[1];
    repeat (10) @(negedge clk);
    #3;
    check("rst_no_stale", 32'(emit_cnt[1] - base), 32'd0);
    check("rst_idle_valid", 32'(ovalid[1]), 32'd0);

    // Unstalled random traffic: exact latency on every beat.
    lat_chk = 1'b1;
    for (int n = 0; n < 300; n++) drive_random(70, 100);
    drain("unstalled");
    lat_chk = 1'b0;

    // Random valid/ready traffic until every instance has taken 1000 beats.
    for (int i = 0; i < int'(NI); i++) base_acc[i] = acc_cnt[i];
    done = 1'b0;
    for (int n = 0; n < 20000 && !done; n++) begin
      drive_random(75, 60);
      done = 1'b1;
      for (int i = 0; i < int'(NI); i++) begin
        if (acc_cnt[i] - base_acc[i] < 1000) done = 1'b0;
      end
    end
    check("sweep_beats_done", 32'(done), 32'd1);
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
